cic_decimator_iq: RTL and testbench



---
 rtl/cic_decimator_iq.sv | 113 +++++++++++
 tb/tb_cic_decimator_iq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decimator_iq.sv
// Dual-channel (sine/cosine) CIC decimator; one shared decimation counter keeps both channels aligned.
// Optional macro CIC_ROUND_EN selects round-half-up with positive saturation instead of truncation.
module cic_decimator_iq_chan #(
    parameter int IN_WIDTH   = 12,
    parameter int OUT_WIDTH  = 12,
    parameter int STAGES     = 3,
    parameter int DECIM_LOG2 = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        strobe,
    input  logic [STAGES:0]             stb_d,
    input  logic signed [IN_WIDTH-1:0]  in_x,
    output logic signed [OUT_WIDTH-1:0] out_x
);
    localparam int W     = IN_WIDTH + STAGES * DECIM_LOG2;
    localparam int SHIFT = W - OUT_WIDTH;

    logic signed [W-1:0]         x_ext;
    logic signed [W-1:0]         integ [STAGES];
    logic signed [W-1:0]         comb  [STAGES+1];
    logic signed [W-1:0]         dly   [STAGES];
    logic signed [OUT_WIDTH-1:0] sliced;

    assign x_ext = {{(W-IN_WIDTH){in_x[IN_WIDTH-1]}}, in_x};

`ifdef CIC_ROUND_EN
    // Adding half an output LSB before flooring equals adding the bit just below the slice.
    logic signed [OUT_WIDTH-1:0] trunc;
    logic                        half;
    assign trunc = comb[STAGES][W-1 -: OUT_WIDTH];
    assign half  = comb[STAGES][SHIFT-1];
    always_comb begin
        sliced = trunc + OUT_WIDTH'(half);
        if (half && (trunc == {1'b0, {(OUT_WIDTH-1){1'b1}}}))
            sliced = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
`else
    assign sliced = comb[STAGES][W-1 -: OUT_WIDTH];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                integ[k] <= '0;
                dly[k]   <= '0;
            end
            for (int unsigned k = 0; k <= STAGES; k++)
                comb[k] <= '0;
            out_x <= '0;
        end else begin
            integ[0] <= integ[0] + x_ext;
            for (int unsigned k = 1; k < STAGES; k++)
                integ[k] <= integ[k] + integ[k-1];
            if (strobe)
                comb[0] <= integ[STAGES-1];
            // Comb stage k fires k cycles after the capture, so each stage sees the previous result.
            for (int unsigned k = 1; k <= STAGES; k++) begin
                if (stb_d[k-1]) begin
                    comb[k]  <= comb[k-1] - dly[k-1];
                    dly[k-1] <= comb[k-1];
                end
            end
            if (stb_d[STAGES])
                out_x <= sliced;
        end
    end
endmodule

module cic_decimator_iq #(
    parameter int IN_WIDTH   = 12,
    parameter int OUT_WIDTH  = 12,
    parameter int STAGES     = 3,
    parameter int DECIM_LOG2 = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [IN_WIDTH-1:0]  in_sin,
    input  logic signed [IN_WIDTH-1:0]  in_cos,
    output logic signed [OUT_WIDTH-1:0] out_sin,
    output logic signed [OUT_WIDTH-1:0] out_cos,
    output logic                        out_valid
);
    logic [DECIM_LOG2-1:0] cnt;
    logic                  strobe;
    logic [STAGES:0]       stb_d;

    assign strobe = (cnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            stb_d     <= '0;
            out_valid <= 1'b0;
        end else begin
            cnt       <= cnt + DECIM_LOG2'(1);
            stb_d     <= {stb_d[STAGES-1:0], strobe};
            out_valid <= stb_d[STAGES];
        end
    end

    cic_decimator_iq_chan #(
        .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .STAGES(STAGES), .DECIM_LOG2(DECIM_LOG2)
    ) u_sin (
        .clk(clk), .rst_n(rst_n), .strobe(strobe), .stb_d(stb_d), .in_x(in_sin), .out_x(out_sin)
    );

    cic_decimator_iq_chan #(
        .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .STAGES(STAGES), .DECIM_LOG2(DECIM_LOG2)
    ) u_cos (
        .clk(clk), .rst_n(rst_n), .strobe(strobe), .stb_d(stb_d), .in_x(in_cos), .out_x(out_cos)
    );
endmodule

// File: tb/tb_cic_decimator_iq.sv
// Bench for cic_decimator_iq: a 12-bit-output and an 8-bit-output instance (R=16, 3 stages),
// checked against a closed-form binomial-weight model of the CIC response.
module tb_cic_decimator_iq;
    localparam int R    = 16;
    localparam int S    = 3;
    localparam int W    = 12 + S * 4;
    localparam int LAT  = R + S + 1;
`ifdef CIC_ROUND_EN
    localparam int B_POS8 = 1;
    localparam int B_NEG8 = 0;
`else
    localparam int B_POS8 = 0;
    localparam int B_NEG8 = -1;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [11:0] a_sin = '0, a_cos = '0, b_sin = '0, b_cos = '0;
    logic signed [11:0] ao_sin, ao_cos;
    logic signed [7:0]  bo_sin, bo_cos;
    logic               a_valid, b_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int xh [4][$];

    always #5 clk = ~clk;

    cic_decimator_iq #(.IN_WIDTH(12), .OUT_WIDTH(12), .STAGES(3), .DECIM_LOG2(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_sin(a_sin), .in_cos(a_cos),
        .out_sin(ao_sin), .out_cos(ao_cos), .out_valid(a_valid)
    );
    cic_decimator_iq #(.IN_WIDTH(12), .OUT_WIDTH(8), .STAGES(3), .DECIM_LOG2(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_sin(b_sin), .in_cos(b_cos),
        .out_sin(bo_sin), .out_cos(bo_cos), .out_valid(b_valid)
    );

    function automatic longint choose(int m, int k);
        longint r = 1;
        if (m < k) return 0;
        for (int i = 0; i < k; i++) r = r * (m - i) / (i + 1);
        return r;
    endfunction

    // Output of S cascaded running sums seen at cycle n (samples 0..n-1 contribute).
    function automatic longint istage(int ch, int n);
        longint s = 0;
        for (int i = 0; i < n; i++) s += longint'(xh[ch][i]) * choose(n - 1 - i, S - 1);
        return s;
    endfunction

    // m-th decimated output: S-th difference (stride R) of the integrated signal, wrapped to W bits.
    function automatic int expect_out(int ch, int m);
        longint v = 0;
        longint r;
        int outw = (ch < 2) ? 12 : 8;
        int sh   = W - outw;
        for (int k = 0; k <= S; k++) begin
            int n = m * R + R - 1 - k * R;
            if (n > 0) v += ((k % 2) ? -1 : 1) * choose(S, k) * istage(ch, n);
        end
        v = v & ((64'sd1 <<< W) - 1);
        if (v >= (64'sd1 <<< (W - 1))) v -= (64'sd1 <<< W);
`ifdef CIC_ROUND_EN
        r = (v + (64'sd1 <<< (sh - 1))) >>> sh;
        if (r > (64'sd1 <<< (outw - 1)) - 1) r = (64'sd1 <<< (outw - 1)) - 1;
`else
        r = v >>> sh;
`endif
        return int'(r);
    endfunction

    function automatic bit valid_due(int c);
        return (c >= LAT) && ((c - LAT) % R == 0);
    endfunction

    task automatic clear_hist();
        for (int ch = 0; ch < 4; ch++) xh[ch].delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_hist();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one cycle of input from a negedge and return at the following negedge.
    task automatic step(input int as, input int ac, input int bs, input int bc);
        a_sin = 12'(as); a_cos = 12'(ac); b_sin = 12'(bs); b_cos = 12'(bc);
        xh[0].push_back(as); xh[1].push_back(ac); xh[2].push_back(bs); xh[3].push_back(bc);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int rnd12();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks += 4;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b/%b, want 0/0", a_valid, b_valid);
        end
        if (ao_sin !== 0 || ao_cos !== 0) begin
            n_fail++; $display("FAIL reset_a_out: got %0d/%0d, want 0/0", ao_sin, ao_cos);
        end
        if (bo_sin !== 0 || bo_cos !== 0) begin
            n_fail++; $display("FAIL reset_b_out: got %0d/%0d, want 0/0", bo_sin, bo_cos);
        end
        @(negedge clk);
        if (a_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold: got valid %b, want 0", a_valid);
        end
    endtask

    task automatic test_dc();
        do_reset();
        for (int c = 0; c < 10 * R; c++) begin
            step(100, -100, 8, -8);
            n_checks++;
            if (a_valid !== valid_due(c + 1) || b_valid !== valid_due(c + 1)) begin
                n_fail++;
                $display("FAIL dc_valid cycle %0d: got %b/%b, want %b", c + 1, a_valid, b_valid, valid_due(c + 1));
            end
            if (valid_due(c + 1) && (c + 1 - LAT) / R >= S) begin
                n_checks += 2;
                if (ao_sin !== 100 || ao_cos !== -100) begin
                    n_fail++; $display("FAIL dc_a: got %0d/%0d, want 100/-100", ao_sin, ao_cos);
                end
                if (bo_sin !== B_POS8 || bo_cos !== B_NEG8) begin
                    n_fail++; $display("FAIL dc_b8: got %0d/%0d, want %0d/%0d", bo_sin, bo_cos, B_POS8, B_NEG8);
                end
            end
        end
    endtask

    task automatic test_full_scale();
        do_reset();
        for (int c = 0; c < 10 * R; c++) begin
            step(2047, -2048, 2047, -2048);
            n_checks++;
            if (a_valid !== valid_due(c + 1)) begin
                n_fail++; $display("FAIL fs_valid cycle %0d: got %b, want %b", c + 1, a_valid, valid_due(c + 1));
            end
            if (valid_due(c + 1) && (c + 1 - LAT) / R >= S) begin
                n_checks += 2;
                if (ao_sin !== 2047 || ao_cos !== -2048) begin
                    n_fail++; $display("FAIL fs_a: got %0d/%0d, want 2047/-2048", ao_sin, ao_cos);
                end
                if (bo_sin !== 127 || bo_cos !== -128) begin
                    n_fail++; $display("FAIL fs_b: got %0d/%0d, want 127/-128", bo_sin, bo_cos);
                end
            end
        end
    endtask

    task automatic test_nyquist();
        do_reset();
        for (int c = 0; c < 12 * R; c++) begin
            step((c % 2) ? -1000 : 1000, rnd12(), rnd12(), rnd12());
            if (valid_due(c + 1)) begin
                int m = (c + 1 - LAT) / R;
                n_checks += 2;
                if (ao_cos !== expect_out(1, m)) begin
                    n_fail++; $display("FAIL nyq_cos m=%0d: got %0d, want %0d", m, ao_cos, expect_out(1, m));
                end
                if (m >= S && (ao_sin > 1 || ao_sin < -1)) begin
                    n_fail++; $display("FAIL nyq_sin m=%0d: got %0d, want 0 +/-1", m, ao_sin);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int c = 0; c < 3 * R + 4 + 5; c++) step(100, -100, 8, -8);
        rst_n = 1'b0;
        #1;
        n_checks += 2;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_valid: got %b/%b, want 0/0", a_valid, b_valid);
        end
        if (ao_sin !== 0 || ao_cos !== 0 || bo_sin !== 0 || bo_cos !== 0) begin
            n_fail++; $display("FAIL midrst_out: got %0d/%0d/%0d/%0d, want 0", ao_sin, ao_cos, bo_sin, bo_cos);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_hist();
        for (int c = 0; c < 6 * R; c++) begin
            step(100, -100, 8, -8);
            n_checks++;
            if (a_valid !== valid_due(c + 1)) begin
                n_fail++; $display("FAIL midrst_timing cycle %0d: got %b, want %b", c + 1, a_valid, valid_due(c + 1));
            end
            if (valid_due(c + 1) && (c + 1 - LAT) / R >= S) begin
                n_checks++;
                if (ao_sin !== 100 || ao_cos !== -100) begin
                    n_fail++; $display("FAIL midrst_dc: got %0d/%0d, want 100/-100", ao_sin, ao_cos);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 4096; c++) begin
            step(rnd12(), rnd12(), rnd12(), rnd12());
            n_checks++;
            if (a_valid !== valid_due(c + 1) || b_valid !== valid_due(c + 1)) begin
                n_fail++;
                $display("FAIL rand_valid cycle %0d: got %b/%b, want %b", c + 1, a_valid, b_valid, valid_due(c + 1));
            end
            if (valid_due(c + 1)) begin
                int m = (c + 1 - LAT) / R;
                int e0 = expect_out(0, m);
                int e1 = expect_out(1, m);
                int e2 = expect_out(2, m);
                int e3 = expect_out(3, m);
                n_checks += 2;
                if (ao_sin !== e0 || ao_cos !== e1) begin
                    n_fail++; $display("FAIL rand_a m=%0d: got %0d/%0d, want %0d/%0d", m, ao_sin, ao_cos, e0, e1);
                end
                if (bo_sin !== e2 || bo_cos !== e3) begin
                    n_fail++; $display("FAIL rand_b m=%0d: got %0d/%0d, want %0d/%0d", m, bo_sin, bo_cos, e2, e3);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_dc();
        test_full_scale();
        test_nyquist();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
